// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-stage types and constants
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        EXEC = 2'd3
    } fetch_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_next.sv
// rtl/pc_next.sv - combinational next-pc selection for the fetch stage
module pc_next (
    input  logic [31:0] pc,
    input  logic [31:0] target,
    input  logic        jump,
    input  logic        beq_control,
    input  logic        bne_control,
    input  logic        zero,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc,
    output logic        taken_misaligned
);

    logic taken;

    // Resolve branch outcome; taken targets are forced word aligned, low bits only flag an error
    always_comb begin
        taken            = jump | (beq_control & zero) | (bne_control & ~zero);
        pc_plus4         = pc + 32'd4;
        next_pc          = taken ? {target[31:2], 2'b00} : pc_plus4;
        taken_misaligned = taken & (target[1:0] != 2'b00);
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with handshake memory port
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        instr_done,
    input  logic        beq_control,
    input  logic        bne_control,
    input  logic        jump,
    input  logic        zero,
    input  logic [31:0] target,
    output logic        misalign,
    output logic [31:0] retired
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic         capture;
    logic         retire;
    logic [31:0]  next_pc;
    logic         taken_misaligned;

    pc_next u_pc_next (
        .pc               (pc),
        .target           (target),
        .jump             (jump),
        .beq_control      (beq_control),
        .bne_control      (bne_control),
        .zero             (zero),
        .pc_plus4         (pc_plus4),
        .next_pc          (next_pc),
        .taken_misaligned (taken_misaligned)
    );

    assign imem_addr = pc;

    // State register; reset abandons any outstanding request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake decode; rvalid only matters in REQ with gnt, or in WAIT
    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        capture     = 1'b0;
        retire      = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_gnt) begin
                    if (imem_rvalid) begin
                        capture = 1'b1;
                        state_d = EXEC;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    capture = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                instr_valid = 1'b1;
                if (instr_done) begin
                    retire  = 1'b1;
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Instruction latch, pc advance, sticky misalign flag and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            instr    <= NOP_INSTR;
            misalign <= 1'b0;
            retired  <= 32'd0;
        end else begin
            if (capture) begin
                instr <= imem_rdata;
            end
            if (retire) begin
                pc      <= next_pc;
                retired <= retired + 32'd1;
                if (taken_misaligned) begin
                    misalign <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        rst_n_hi;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_done;
    logic        beq_control;
    logic        bne_control;
    logic        jump;
    logic        zero;
    logic [31:0] target;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign;
    logic [31:0] retired;

    logic        h_imem_req;
    logic [31:0] h_imem_addr;
    logic [31:0] h_instr;
    logic        h_instr_valid;
    logic [31:0] h_pc;
    logic [31:0] h_pc_plus4;
    logic        h_misalign;
    logic [31:0] h_retired;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_entry_t;

    sb_entry_t   sb_q[$];
    sb_entry_t   exp_e;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_pc;
    logic [31:0] model_retired;
    logic        model_mis;
    logic [31:0] seen_addr;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
        .instr_done(instr_done), .beq_control(beq_control), .bne_control(bne_control),
        .jump(jump), .zero(zero), .target(target),
        .misalign(misalign), .retired(retired)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_hi (
        .clk(clk), .rst_n(rst_n_hi),
        .imem_req(h_imem_req), .imem_addr(h_imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr(h_instr), .instr_valid(h_instr_valid), .pc(h_pc), .pc_plus4(h_pc_plus4),
        .instr_done(instr_done), .beq_control(beq_control), .bne_control(bne_control),
        .jump(jump), .zero(zero), .target(target),
        .misalign(h_misalign), .retired(h_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_req();
        for (int i = 0; i < 20; i++) begin
            if (imem_req === 1'b1) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL wait_req timeout: imem_req=%b required 1", imem_req);
    endtask

    task automatic fetch(input logic [31:0] data, input int lat);
        wait_req();
        seen_addr = imem_addr;
        sb_q.push_back('{model_pc, data});
        imem_gnt    = 1'b1;
        imem_rdata  = data;
        imem_rvalid = (lat == 0);
        @(negedge clk);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        if (lat > 0) begin
            repeat (lat - 1) @(negedge clk);
            imem_rvalid = 1'b1;
            @(negedge clk);
            imem_rvalid = 1'b0;
        end
    endtask

    task automatic retire(input logic j, input logic b, input logic n, input logic z,
                          input logic [31:0] t);
        logic tk;
        tk = j | (b & z) | (n & ~z);
        jump = j; beq_control = b; bne_control = n; zero = z; target = t;
        instr_done = 1'b1;
        if (tk && t[1:0] != 2'b00) model_mis = 1'b1;
        model_pc = tk ? {t[31:2], 2'b00} : model_pc + 32'd4;
        model_retired = model_retired + 32'd1;
        @(negedge clk);
        instr_done = 1'b0; jump = 1'b0; beq_control = 1'b0; bne_control = 1'b0;
        zero = 1'b0; target = 32'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0 || instr !== 32'h13 ||
            misalign !== 1'b0 || retired !== 32'd0 || pc_plus4 !== 32'h4) begin
            errors++;
            $display("FAIL reset_state: req=%b iv=%b pc=%h instr=%h mis=%b ret=%0d p4=%h required 0 0 0 13 0 0 4",
                     imem_req, instr_valid, pc, instr, misalign, retired, pc_plus4);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_release: imem_req=%b required 0", imem_req);
        end
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL first_req: req=%b addr=%h required 1 00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_streaming();
        imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        for (int k = 0; k < 5; k++) begin
            wait_req();
            checks++;
            if (imem_addr !== 32'(k * 4)) begin
                errors++;
                $display("FAIL stream_addr[%0d]: got %h required %h", k, imem_addr, 32'(k * 4));
            end
            sb_q.push_back('{model_pc, 32'h0050_0093});
            @(negedge clk);
            exp_e = sb_q.pop_front();
            checks++;
            if (instr_valid !== 1'b1 || instr !== exp_e.instr || pc !== exp_e.pc) begin
                errors++;
                $display("FAIL stream_exec[%0d]: iv=%b instr=%h pc=%h required 1 %h %h",
                         k, instr_valid, instr, pc, exp_e.instr, exp_e.pc);
            end
            retire(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
            checks++;
            if (retired !== model_retired) begin
                errors++;
                $display("FAIL stream_retired[%0d]: got %0d required %0d", k, retired, model_retired);
            end
        end
        imem_gnt = 1'b0; imem_rvalid = 1'b0;
    endtask

    task automatic test_wait_latency();
        wait_req();
        sb_q.push_back('{model_pc, 32'hCAFE_0013});
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL wait_cycle[N+%0d]: req=%b iv=%b required 0 0", c, imem_req, instr_valid);
            end
            if (c == 3) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hCAFE_0013;
            end
            @(negedge clk);
        end
        imem_rvalid = 1'b0;
        exp_e = sb_q.pop_front();
        checks++;
        if (instr_valid !== 1'b1 || instr !== exp_e.instr || pc !== exp_e.pc) begin
            errors++;
            $display("FAIL wait_capture: iv=%b instr=%h pc=%h required 1 %h %h",
                     instr_valid, instr, pc, exp_e.instr, exp_e.pc);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rvalid = 1'b0;
        checks++;
        if (instr !== exp_e.instr || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL exec_rvalid_ignored: instr=%h iv=%b req=%b required %h 1 0",
                     instr, instr_valid, imem_req, exp_e.instr);
        end
        retire(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic test_branch();
        logic [31:0] want [3];
        logic        cb [3];
        logic        cn [3];
        logic        cz [3];
        logic [31:0] ct [3];
        want[0] = 32'h40; cb[0] = 1'b1; cn[0] = 1'b0; cz[0] = 1'b1; ct[0] = 32'h40;
        want[1] = 32'h14; cb[1] = 1'b1; cn[1] = 1'b0; cz[1] = 1'b0; ct[1] = 32'h40;
        want[2] = 32'h80; cb[2] = 1'b0; cn[2] = 1'b1; cz[2] = 1'b0; ct[2] = 32'h80;
        for (int k = 0; k < 3; k++) begin
            fetch(32'h0000_0013, 0);
            void'(sb_q.pop_front());
            retire(1'b1, 1'b0, 1'b0, 1'b0, 32'h10);
            fetch(32'h0000_0463, 1);
            exp_e = sb_q.pop_front();
            checks++;
            if (seen_addr !== 32'h10 || pc !== exp_e.pc || instr !== exp_e.instr) begin
                errors++;
                $display("FAIL branch_setup[%0d]: addr=%h pc=%h instr=%h required 00000010 %h %h",
                         k, seen_addr, pc, instr, exp_e.pc, exp_e.instr);
            end
            retire(1'b0, cb[k], cn[k], cz[k], ct[k]);
            wait_req();
            checks++;
            if (imem_addr !== want[k] || imem_addr !== model_pc) begin
                errors++;
                $display("FAIL branch_target[%0d]: addr=%h required %h", k, imem_addr, want[k]);
            end
        end
    endtask

    task automatic test_done_outside_exec();
        wait_req();
        instr_done = 1'b1; jump = 1'b1; target = 32'h200;
        imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
        @(negedge clk);
        instr_done = 1'b0; jump = 1'b0; target = 32'd0; imem_rvalid = 1'b0;
        checks++;
        if (pc !== model_pc || retired !== model_retired || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_outside_exec: pc=%h ret=%0d req=%b iv=%b required %h %0d 1 0",
                     pc, retired, imem_req, instr_valid, model_pc, model_retired);
        end
    endtask

    task automatic test_misalign();
        checks++;
        if (misalign !== 1'b0) begin
            errors++;
            $display("FAIL misalign_initial: got %b required 0", misalign);
        end
        fetch(32'h0000_006F, 0);
        void'(sb_q.pop_front());
        retire(1'b1, 1'b0, 1'b0, 1'b0, 32'h102);
        wait_req();
        checks++;
        if (pc !== 32'h100 || misalign !== 1'b1) begin
            errors++;
            $display("FAIL misalign_jump: pc=%h mis=%b required 00000100 1", pc, misalign);
        end
        for (int k = 0; k < 2; k++) begin
            fetch(32'h0000_0013, k);
            exp_e = sb_q.pop_front();
            checks++;
            if (pc !== exp_e.pc || instr !== exp_e.instr) begin
                errors++;
                $display("FAIL misalign_follow[%0d]: pc=%h instr=%h required %h %h",
                         k, pc, instr, exp_e.pc, exp_e.instr);
            end
            retire(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        end
        checks++;
        if (misalign !== 1'b1 || misalign !== model_mis || pc !== 32'h108) begin
            errors++;
            $display("FAIL misalign_sticky: mis=%b pc=%h required 1 00000108", misalign, pc);
        end
    endtask

    task automatic test_wrap();
        int i;
        rst_n = 1'b0;
        rst_n_hi = 1'b0;
        @(negedge clk);
        rst_n_hi = 1'b1;
        checks++;
        if (h_pc !== 32'hFFFF_FFFC || h_pc_plus4 !== 32'h0 || h_misalign !== 1'b0 || h_retired !== 32'd0) begin
            errors++;
            $display("FAIL wrap_reset: pc=%h p4=%h mis=%b ret=%0d required fffffffc 00000000 0 0",
                     h_pc, h_pc_plus4, h_misalign, h_retired);
        end
        for (i = 0; i < 20 && h_imem_req !== 1'b1; i++) @(negedge clk);
        imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
        @(negedge clk);
        imem_gnt = 1'b0; imem_rvalid = 1'b0;
        checks++;
        if (h_instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_exec: iv=%b required 1", h_instr_valid);
        end
        instr_done = 1'b1;
        @(negedge clk);
        instr_done = 1'b0;
        checks++;
        if (h_pc !== 32'h0 || h_imem_addr !== 32'h0 || h_retired !== 32'd1 || h_imem_req !== 1'b1) begin
            errors++;
            $display("FAIL wrap_pc: pc=%h addr=%h ret=%0d req=%b required 0 0 1 1",
                     h_pc, h_imem_addr, h_retired, h_imem_req);
        end
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        checks++;
        if (h_imem_req !== 1'b0 || h_instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_wait: req=%b iv=%b required 0 0", h_imem_req, h_instr_valid);
        end
        #2 rst_n_hi = 1'b0;
        #1;
        checks++;
        if (h_pc !== 32'hFFFF_FFFC || h_instr !== 32'h13 || h_retired !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: pc=%h instr=%h ret=%0d required fffffffc 00000013 0",
                     h_pc, h_instr, h_retired);
        end
        @(negedge clk);
        rst_n_hi = 1'b1;
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0BAD;
        #1;
        checks++;
        if (h_imem_req !== 1'b0 || h_instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: req=%b iv=%b required 0 0", h_imem_req, h_instr_valid);
        end
        repeat (2) @(negedge clk);
        imem_rvalid = 1'b0;
        checks++;
        if (h_instr_valid !== 1'b0 || h_instr !== 32'h13 || h_imem_req !== 1'b1) begin
            errors++;
            $display("FAIL late_rvalid: iv=%b instr=%h req=%b required 0 00000013 1",
                     h_instr_valid, h_instr, h_imem_req);
        end
    endtask

    initial begin
        rst_n = 1'b0; rst_n_hi = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        instr_done = 1'b0; beq_control = 1'b0; bne_control = 1'b0;
        jump = 1'b0; zero = 1'b0; target = 32'd0;
        model_pc = 32'h0; model_retired = 32'd0; model_mis = 1'b0; seen_addr = 32'd0;
        test_reset();
        test_streaming();
        test_wait_latency();
        test_done_outside_exec();
        test_branch();
        test_misalign();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
